y86_execute_pipe: RTL and testbench
===================================

// Module: y86_execute_pipe
// PURPOSE
//  Registered, handshaked Y86-64 execute stage: ALU, condition-code (CC) register, Cnd evaluation
//  for jXX/cmovXX, and cmov destination squash. Sits between decode and memory stages.
//  Data width is parametrised. Valid/ready on both sides, flush and exception-blocking of CC updates.
// PARAMETERS
//  WIDTH       64   datapath width in bits (32 or 64)
//  STACK_STEP  WIDTH/8   stack-pointer increment for push/pop/call/ret
// PORTS
//  clk_i        in   1      clock, single domain
//  rst_n_i      in   1      asynchronous active-low reset
//  in_valid_i   in   1      decode bundle valid
//  in_ready_o   out  1      stage can accept
//  icode_i      in   4      instruction code
//  ifun_i       in   4      function code
//  valA_i       in   WIDTH  operand A
//  valB_i       in   WIDTH  operand B
//  valC_i       in   WIDTH  immediate/displacement
//  dstE_i       in   4      E destination register id
//  dstM_i       in   4      M destination register id
//  flush_i      in   1      kill held result and drop this cycle's input
//  cc_block_i   in   1      downstream exception pending: suppress CC update
//  out_valid_o  out  1      result valid
//  out_ready_i  in   1      memory stage accepts
//  valE_o       out  WIDTH  ALU result
//  valA_o       out  WIDTH  valA passthrough
//  cnd_o        out  1      condition outcome
//  dstE_o       out  4      dstE, 4'hF (RNONE) when cmov fails
//  dstM_o       out  4      dstM passthrough
//  err_o        out  1      invalid ifun for OPq/jXX/cmovXX
//  cc_o         out  3      {ZF,SF,OF} current CC register
// BEHAVIOUR
//  - Reset (async): out_valid_o=0, valE_o=0, valA_o=0, cnd_o=0, dstE_o=dstM_o=4'hF, err_o=0, cc={1,0,0}.
//  - in_ready_o = ~flush_i & (~out_valid_o | out_ready_i). Accept = in_valid_i & in_ready_o.
//  - Latency 1: accepted bundle appears on outputs next cycle; output regs hold while out_valid_o & ~out_ready_i.
//  - Pop without accept: out_valid_o -> 0. Flush: out_valid_o -> 0 next edge, no accept, no CC write.
//  - aluA: valA for OPq/rrmov; valC for irmov/rmmov/mrmov; -STACK_STEP for call/push; +STACK_STEP for ret/pop.
//  - aluB: valB for OPq/rmmov/mrmov/call/push/ret/pop; 0 for rrmov/irmov; nop/halt/jXX: valE=0.
//  - ALU fun = ifun for OPq, else ADD. ADD aluB+aluA; SUB aluB-aluA; AND; XOR. Mod 2^WIDTH, wrap silent.
//  - Flags: ZF=(r==0); SF=r[WIDTH-1]; OF add: a,b same sign & r differs; sub: b,a differ & r differs from b; AND/XOR: 0.
//  - CC written at accept edge iff icode==OPq & ifun<=3 & ~cc_block_i & ~flush_i. Next instr sees new CC.
//  - Cnd (vs CC before this instr): 0 always,1 le (SF^OF)|ZF,2 l SF^OF,3 e ZF,4 ne ~ZF,5 ge ~(SF^OF),6 g ~(SF^OF)&~ZF.
//    cnd_o=Cnd for jXX/rrmov(cmov); 0 otherwise. dstE_o=4'hF when rrmov & ~Cnd.
//  - ifun>3 on OPq or >6 on jXX/cmov: err_o=1, cnd_o=0, dstE_o=4'hF, CC unchanged; bundle still passes.
//  - Unknown icode (>4'hB): valE=0, err_o=0 (decode owns INS status).
//  - Reset mid-transfer: held result discarded, CC reset; no partial updates.
// STRUCTURE
//  - y86_pkg: icode/ifun/ALU-fun localparams, RNONE=4'hF, cond_eval function (ifun, cc) -> cnd.
//  - Sub-module y86_alu #(WIDTH): combinational a,b,fun -> result, zf, sf, of.
//  - Top: operand mux, CC register, output pipeline register + handshake.
// TESTING
//  - OPq add 3+5, WIDTH=64 -> valE=8, cc={0,0,0}; WIDTH=32 0x7FFFFFFF+1 -> 0x80000000, cc={0,1,1}.
//  - subq valA=5 valB=5 then jE next cycle -> cc={1,0,0}, jE cnd=1; valA=5 valB=3 then jL -> cnd=1 (3-5<0).
//  - cmovE after ZF=0, dstE_i=3 -> cnd=0, dstE_o=4'hF; cmovNE same CC -> cnd=1, dstE_o=3.
//  - push valB=0x8000 -> 0x7FF8; pop valB=0x7FF8 -> 0x8000 (WIDTH=64); call/ret identical.
//  - out_ready_i=0 for 3 cycles with result held -> in_ready_o=0, outputs stable, no CC change.
//  - subq with cc_block_i=1 -> CC unchanged; flush_i with in_valid -> out_valid_o=0, CC unchanged; ifun=7 OPq -> err_o=1.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the condition evaluator used by the execute stage.
package y86_pkg;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [3:0] RNONE = 4'hF;

    // cc is packed {ZF,SF,OF}
    function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
        logic zf, sf, of;
        zf = cc[2];
        sf = cc[1];
        of = cc[0];
        case (ifun)
            C_YES:   return 1'b1;
            C_LE:    return (sf ^ of) | zf;
            C_L:     return sf ^ of;
            C_E:     return zf;
            C_NE:    return ~zf;
            C_GE:    return ~(sf ^ of);
            C_G:     return ~(sf ^ of) & ~zf;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/y86_alu.sv
// Combinational Y86 ALU: result = b OP a, with zero/sign/overflow flags.
module y86_alu
    import y86_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       fun_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zf_o,
    output logic             sf_o,
    output logic             of_o
);

    logic w_a_msb, w_b_msb, w_r_msb;

    assign w_a_msb = a_i[WIDTH-1];
    assign w_b_msb = b_i[WIDTH-1];
    assign w_r_msb = result_o[WIDTH-1];

    always_comb begin
        result_o = b_i + a_i;
        of_o     = 1'b0;
        case (fun_i)
            ALU_ADD: begin
                result_o = b_i + a_i;
                of_o     = (w_a_msb == w_b_msb) & (w_r_msb != w_a_msb);
            end
            ALU_SUB: begin
                result_o = b_i - a_i;
                of_o     = (w_a_msb != w_b_msb) & (w_r_msb != w_b_msb);
            end
            ALU_AND: result_o = b_i & a_i;
            ALU_XOR: result_o = b_i ^ a_i;
            default: result_o = b_i + a_i;
        endcase
    end

    assign zf_o = (result_o == '0);
    assign sf_o = w_r_msb;

endmodule

// File: rtl/y86_execute_pipe.sv
// Y86-64 execute stage: operand select, ALU, CC register, Cnd evaluation and
// a single valid/ready output register towards the memory stage.
module y86_execute_pipe
    import y86_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int STACK_STEP = WIDTH / 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       icode_i,
    input  logic [3:0]       ifun_i,
    input  logic [WIDTH-1:0] valA_i,
    input  logic [WIDTH-1:0] valB_i,
    input  logic [WIDTH-1:0] valC_i,
    input  logic [3:0]       dstE_i,
    input  logic [3:0]       dstM_i,
    input  logic             flush_i,
    input  logic             cc_block_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] valE_o,
    output logic [WIDTH-1:0] valA_o,
    output logic             cnd_o,
    output logic [3:0]       dstE_o,
    output logic [3:0]       dstM_o,
    output logic             err_o,
    output logic [2:0]       cc_o
);

    localparam logic [WIDTH-1:0] STEP     = WIDTH'(STACK_STEP);
    localparam logic [WIDTH-1:0] NEG_STEP = '0 - STEP;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_valE, r_valA;
    logic             r_cnd, r_err;
    logic [3:0]       r_dstE, r_dstM;
    logic [2:0]       r_cc;

    logic             w_accept, w_is_opq, w_is_jxx, w_is_rrmov, w_bad_fun;
    logic             w_cnd, w_cc_we;
    logic [3:0]       w_dstE, w_alu_fun;
    logic [WIDTH-1:0] w_alu_a, w_alu_b, w_alu_r;
    logic             w_zf, w_sf, w_of;

    assign in_ready_o = ~flush_i & (~r_out_valid | out_ready_i);
    assign w_accept   = in_valid_i & in_ready_o;

    assign w_is_opq   = (icode_i == I_OPQ);
    assign w_is_jxx   = (icode_i == I_JXX);
    assign w_is_rrmov = (icode_i == I_RRMOV);
    assign w_bad_fun  = (w_is_opq & (ifun_i > ALU_XOR)) |
                        ((w_is_jxx | w_is_rrmov) & (ifun_i > C_G));

    // Unlisted icodes (halt, nop, jXX, unknown) leave both operands at zero so valE is 0.
    always_comb begin
        w_alu_a   = '0;
        w_alu_b   = '0;
        w_alu_fun = ALU_ADD;
        case (icode_i)
            I_OPQ: begin
                w_alu_a   = valA_i;
                w_alu_b   = valB_i;
                w_alu_fun = w_bad_fun ? ALU_ADD : ifun_i;
            end
            I_RRMOV: w_alu_a = valA_i;
            I_IRMOV: w_alu_a = valC_i;
            I_RMMOV, I_MRMOV: begin
                w_alu_a = valC_i;
                w_alu_b = valB_i;
            end
            I_CALL, I_PUSH: begin
                w_alu_a = NEG_STEP;
                w_alu_b = valB_i;
            end
            I_RET, I_POP: begin
                w_alu_a = STEP;
                w_alu_b = valB_i;
            end
            default: ;
        endcase
    end

    y86_alu #(.WIDTH(WIDTH)) u_alu (
        .a_i      (w_alu_a),
        .b_i      (w_alu_b),
        .fun_i    (w_alu_fun),
        .result_o (w_alu_r),
        .zf_o     (w_zf),
        .sf_o     (w_sf),
        .of_o     (w_of)
    );

    // Cnd uses the CC as it stood before this instruction.
    assign w_cnd   = (w_is_jxx | w_is_rrmov) & ~w_bad_fun & cond_eval(ifun_i, r_cc);
    assign w_dstE  = (w_bad_fun | (w_is_rrmov & ~w_cnd)) ? RNONE : dstE_i;
    assign w_cc_we = w_accept & w_is_opq & ~w_bad_fun & ~cc_block_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cc <= 3'b100;
        end else if (w_cc_we) begin
            r_cc <= {w_zf, w_sf, w_of};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_out_valid <= 1'b0;
            r_valE      <= '0;
            r_valA      <= '0;
            r_cnd       <= 1'b0;
            r_dstE      <= RNONE;
            r_dstM      <= RNONE;
            r_err       <= 1'b0;
        end else if (flush_i) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_valE      <= w_alu_r;
            r_valA      <= valA_i;
            r_cnd       <= w_cnd;
            r_dstE      <= w_dstE;
            r_dstM      <= dstM_i;
            r_err       <= w_bad_fun;
        end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid_o = r_out_valid;
    assign valE_o      = r_valE;
    assign valA_o      = r_valA;
    assign cnd_o       = r_cnd;
    assign dstE_o      = r_dstE;
    assign dstM_o      = r_dstM;
    assign err_o       = r_err;
    assign cc_o        = r_cc;

endmodule

// File: tb/tb_y86_execute_pipe.sv
// Directed checks of the execute stage: ALU, CC, Cnd, cmov squash, stack ops, handshake.
module tb_y86_execute_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [3:0]  icode = 4'h1, ifun = 4'h0, dstE = 4'hF, dstM = 4'hF;
    logic [63:0] valA = '0, valB = '0, valC = '0;
    logic        flush = 1'b0, cc_block = 1'b0, out_ready = 1'b1;
    logic        out_valid, cnd, err;
    logic [63:0] valE_o, valA_o;
    logic [3:0]  dstE_o, dstM_o;
    logic [2:0]  cc;

    logic        in_valid32 = 1'b0, in_ready32, out_valid32, cnd32, err32;
    logic [3:0]  icode32 = 4'h1, ifun32 = 4'h0;
    logic [31:0] valA32 = '0, valB32 = '0, valE32, valAo32;
    logic [3:0]  dstEo32, dstMo32;
    logic [2:0]  cc32;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    y86_execute_pipe #(.WIDTH(64)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .icode_i(icode), .ifun_i(ifun), .valA_i(valA), .valB_i(valB), .valC_i(valC),
        .dstE_i(dstE), .dstM_i(dstM), .flush_i(flush), .cc_block_i(cc_block),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .valE_o(valE_o), .valA_o(valA_o),
        .cnd_o(cnd), .dstE_o(dstE_o), .dstM_o(dstM_o), .err_o(err), .cc_o(cc)
    );

    y86_execute_pipe #(.WIDTH(32)) dut32 (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid32), .in_ready_o(in_ready32),
        .icode_i(icode32), .ifun_i(ifun32), .valA_i(valA32), .valB_i(valB32), .valC_i(32'd0),
        .dstE_i(4'd1), .dstM_i(4'hF), .flush_i(1'b0), .cc_block_i(1'b0),
        .out_valid_o(out_valid32), .out_ready_i(1'b1), .valE_o(valE32), .valA_o(valAo32),
        .cnd_o(cnd32), .dstE_o(dstEo32), .dstM_o(dstMo32), .err_o(err32), .cc_o(cc32)
    );

    // Present one bundle for a single cycle; outputs are sampled 1ns after the edge.
    task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                        input logic [63:0] b, input logic [3:0] de, input logic [3:0] dm);
        @(negedge clk);
        icode = ic; ifun = fn; valA = a; valB = b; valC = '0; dstE = de; dstM = dm;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("txn icode=%h ifun=%h valA=%h valB=%h -> valE=%h cnd=%b dstE=%h err=%b cc=%b",
                 ic, fn, a, b, valE_o, cnd, dstE_o, err, cc);
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (valE_o !== 64'd0) begin n_err++; $display("FAIL reset_valE: got %h want 0", valE_o); end
        n_cmp++; if (dstE_o !== 4'hF || dstM_o !== 4'hF) begin n_err++; $display("FAIL reset_dst: got %h/%h want f/f", dstE_o, dstM_o); end
        n_cmp++; if (err !== 1'b0 || cnd !== 1'b0) begin n_err++; $display("FAIL reset_err_cnd: got %b/%b want 0/0", err, cnd); end
        n_cmp++; if (cc !== 3'b100) begin n_err++; $display("FAIL reset_cc: got %b want 100", cc); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        send(4'h6, 4'h0, 64'd3, 64'd5, 4'd2, 4'd7);
        n_cmp++; if (valE_o !== 64'd8) begin n_err++; $display("FAIL add_valE: got %h want 8", valE_o); end
        n_cmp++; if (cc !== 3'b000) begin n_err++; $display("FAIL add_cc: got %b want 000", cc); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_out_valid: got %b want 1", out_valid); end
        n_cmp++; if (dstE_o !== 4'd2 || dstM_o !== 4'd7) begin n_err++; $display("FAIL add_dst: got %h/%h want 2/7", dstE_o, dstM_o); end
        n_cmp++; if (valA_o !== 64'd3) begin n_err++; $display("FAIL add_valA: got %h want 3", valA_o); end
    endtask

    task automatic test_add32();
        @(negedge clk);
        icode32 = 4'h6; ifun32 = 4'h0; valA32 = 32'd1; valB32 = 32'h7FFF_FFFF; in_valid32 = 1'b1;
        @(posedge clk);
        #1;
        in_valid32 = 1'b0;
        $display("txn w32 addq 1+7fffffff -> valE=%h cc=%b", valE32, cc32);
        n_cmp++; if (valE32 !== 32'h8000_0000) begin n_err++; $display("FAIL add32_valE: got %h want 80000000", valE32); end
        n_cmp++; if (cc32 !== 3'b011) begin n_err++; $display("FAIL add32_cc: got %b want 011", cc32); end
    endtask

    task automatic test_sub_jump();
        send(4'h6, 4'h1, 64'd5, 64'd5, 4'd2, 4'hF);
        n_cmp++; if (valE_o !== 64'd0 || cc !== 3'b100) begin n_err++; $display("FAIL sub_eq: got valE=%h cc=%b want 0/100", valE_o, cc); end
        send(4'h7, 4'h3, 64'd0, 64'd0, 4'hF, 4'hF);
        n_cmp++; if (cnd !== 1'b1) begin n_err++; $display("FAIL je_cnd: got %b want 1", cnd); end
        n_cmp++; if (valE_o !== 64'd0) begin n_err++; $display("FAIL je_valE: got %h want 0", valE_o); end
        send(4'h6, 4'h1, 64'd5, 64'd3, 4'd2, 4'hF);
        n_cmp++; if (valE_o !== 64'hFFFF_FFFF_FFFF_FFFE || cc !== 3'b010) begin n_err++; $display("FAIL sub_lt: got valE=%h cc=%b want fffffffffffffffe/010", valE_o, cc); end
        send(4'h7, 4'h2, 64'd0, 64'd0, 4'hF, 4'hF);
        n_cmp++; if (cnd !== 1'b1) begin n_err++; $display("FAIL jl_cnd: got %b want 1", cnd); end
        send(4'h7, 4'h6, 64'd0, 64'd0, 4'hF, 4'hF);
        n_cmp++; if (cnd !== 1'b0) begin n_err++; $display("FAIL jg_cnd: got %b want 0", cnd); end
    endtask

    task automatic test_cmov();
        send(4'h2, 4'h3, 64'h55, 64'd0, 4'd3, 4'hF);
        n_cmp++; if (cnd !== 1'b0 || dstE_o !== 4'hF) begin n_err++; $display("FAIL cmove: got cnd=%b dstE=%h want 0/f", cnd, dstE_o); end
        send(4'h2, 4'h4, 64'h55, 64'd0, 4'd3, 4'hF);
        n_cmp++; if (cnd !== 1'b1 || dstE_o !== 4'd3) begin n_err++; $display("FAIL cmovne: got cnd=%b dstE=%h want 1/3", cnd, dstE_o); end
        n_cmp++; if (valE_o !== 64'h55) begin n_err++; $display("FAIL cmovne_valE: got %h want 55", valE_o); end
    endtask

    task automatic test_stack();
        send(4'hA, 4'h0, 64'd0, 64'h8000, 4'd4, 4'hF);
        n_cmp++; if (valE_o !== 64'h7FF8) begin n_err++; $display("FAIL push_valE: got %h want 7ff8", valE_o); end
        send(4'hB, 4'h0, 64'd0, 64'h7FF8, 4'd4, 4'd1);
        n_cmp++; if (valE_o !== 64'h8000) begin n_err++; $display("FAIL pop_valE: got %h want 8000", valE_o); end
        send(4'h8, 4'h0, 64'd0, 64'h8000, 4'd4, 4'hF);
        n_cmp++; if (valE_o !== 64'h7FF8) begin n_err++; $display("FAIL call_valE: got %h want 7ff8", valE_o); end
        send(4'h9, 4'h0, 64'd0, 64'h7FF8, 4'd4, 4'hF);
        n_cmp++; if (valE_o !== 64'h8000) begin n_err++; $display("FAIL ret_valE: got %h want 8000", valE_o); end
        n_cmp++; if (cc !== 3'b010 || cnd !== 1'b0) begin n_err++; $display("FAIL stack_cc: got cc=%b cnd=%b want 010/0", cc, cnd); end
    endtask

    task automatic test_backpressure();
        send(4'h6, 4'h0, 64'd1, 64'd1, 4'd2, 4'hF);
        out_ready = 1'b0;
        @(negedge clk);
        icode = 4'h6; ifun = 4'h1; valA = 64'd7; valB = 64'd7; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
            n_cmp++; if (out_valid !== 1'b1 || valE_o !== 64'd2) begin n_err++; $display("FAIL stall_hold[%0d]: got v=%b valE=%h want 1/2", i, out_valid, valE_o); end
            n_cmp++; if (cc !== 3'b000) begin n_err++; $display("FAIL stall_cc[%0d]: got %b want 000", i, cc); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("txn released subq 7,7 -> valE=%h cc=%b", valE_o, cc);
        n_cmp++; if (valE_o !== 64'd0 || cc !== 3'b100) begin n_err++; $display("FAIL release_result: got valE=%h cc=%b want 0/100", valE_o, cc); end
    endtask

    task automatic test_cc_block_flush();
        cc_block = 1'b1;
        send(4'h6, 4'h1, 64'd1, 64'd5, 4'd2, 4'hF);
        cc_block = 1'b0;
        n_cmp++; if (valE_o !== 64'd4 || cc !== 3'b100) begin n_err++; $display("FAIL cc_block: got valE=%h cc=%b want 4/100", valE_o, cc); end
        @(negedge clk);
        flush = 1'b1; icode = 4'h6; ifun = 4'h0; valA = 64'd1; valB = 64'd1; in_valid = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        $display("txn flush -> out_valid=%b cc=%b", out_valid, cc);
        n_cmp++; if (out_valid !== 1'b0 || cc !== 3'b100) begin n_err++; $display("FAIL flush: got v=%b cc=%b want 0/100", out_valid, cc); end
    endtask

    task automatic test_err();
        send(4'h6, 4'h7, 64'd1, 64'd1, 4'd5, 4'hF);
        n_cmp++; if (err !== 1'b1 || dstE_o !== 4'hF || cnd !== 1'b0) begin n_err++; $display("FAIL opq_err: got err=%b dstE=%h cnd=%b want 1/f/0", err, dstE_o, cnd); end
        n_cmp++; if (cc !== 3'b100 || out_valid !== 1'b1) begin n_err++; $display("FAIL opq_err_cc: got cc=%b v=%b want 100/1", cc, out_valid); end
        send(4'h7, 4'h9, 64'd0, 64'd0, 4'hF, 4'hF);
        n_cmp++; if (err !== 1'b1 || cnd !== 1'b0) begin n_err++; $display("FAIL jxx_err: got err=%b cnd=%b want 1/0", err, cnd); end
        @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pop_idle: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        send(4'h6, 4'h1, 64'd9, 64'd2, 4'd2, 4'hF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || cc !== 3'b100 || dstE_o !== 4'hF) begin n_err++; $display("FAIL reset_mid: got v=%b cc=%b dstE=%h want 0/100/f", out_valid, cc, dstE_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_add32();
        test_sub_jump();
        test_cmov();
        test_stack();
        test_backpressure();
        test_cc_block_flush();
        test_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
